// File: rtl/ama_riscv_icache_if.sv
// Handshake bundle between fetch stage, instruction cache and memory instruction port.
// Latency: wires only; the cache drives its outputs from registers or from its state.
// Backpressure: core_req_ready / mem_req_ready gate requests; responses are not back-pressured.
interface ama_riscv_icache_if #(
    parameter int LINE_W     = 128,
    parameter int MEM_ADDR_W = 14
);
    logic                  core_req_valid;
    logic                  core_req_ready;
    logic [31:0]           core_req_addr;
    logic                  core_rsp_valid;
    logic [31:0]           core_rsp_data;
    logic                  flush;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [MEM_ADDR_W-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [LINE_W-1:0]     mem_rsp_data;

    // The cache itself: serves the core, issues line requests to memory.
    modport slave (
        input  core_req_valid, core_req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output core_req_ready, core_rsp_valid, core_rsp_data, mem_req_valid, mem_req_addr
    );

    // The environment around the cache: fetch stage plus memory port.
    modport master (
        output core_req_valid, core_req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  core_req_ready, core_rsp_valid, core_rsp_data, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ama_riscv_icache.sv
// Direct-mapped read-only instruction cache, 32-bit words out of LINE_W-bit lines.
// Latency: hit 1 cycle after accept; miss 4 cycles plus memory stall/response delay.
// Backpressure: core_req_ready low during a miss; mem request held until mem_req_ready.
module ama_riscv_icache #(
    parameter int SETS       = 16,
    parameter int LINE_W     = 128,
    parameter int MEM_ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    ama_riscv_icache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 4;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;

    // Line storage; contents are meaningless until the matching valid bit is set.
    logic [LINE_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              ready, accept, flush_now, hit, fill_en;
    logic              unused_addr_lsbs;

    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line, input logic [1:0] sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

    assign req_idx   = bus.core_req_addr[IDX_W+3:4];
    assign req_tag   = bus.core_req_addr[31:IDX_W+4];
    assign fill_idx  = addr_q[IDX_W+3:4];
    assign unused_addr_lsbs = ^bus.core_req_addr[1:0];

    // RESP behaves like IDLE for new requests, so the cache is ready in both.
    assign ready     = (state_q == IDLE) || (state_q == RESP);
    assign accept    = ready && bus.core_req_valid;
    // A flush that lands now (input pulse, or one deferred through the miss) wipes the
    // valid bits at this edge, so a request looked up in the same cycle must miss.
    assign flush_now = ready && (bus.flush || ((state_q == RESP) && flush_pend_q));
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush_now;
    assign fill_en   = (state_q == MISS_WAIT) && bus.mem_rsp_valid;

    assign bus.core_req_ready = ready;
    assign bus.core_rsp_valid = rsp_vld_q;
    assign bus.core_rsp_data  = rsp_dat_q;
    assign bus.mem_req_valid  = (state_q == MISS_REQ);
    assign bus.mem_req_addr   = addr_q[MEM_ADDR_W+3:4];

    // Next-state, lookup result, fill bookkeeping and flush handling.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        rsp_vld_d    = 1'b0;
        rsp_dat_d    = rsp_dat_q;

        unique case (state_q)
            IDLE, RESP: begin
                flush_pend_d = 1'b0;
                state_d      = IDLE;
                if (accept) begin
                    addr_d = bus.core_req_addr[31:2];
                    if (hit) begin
                        rsp_vld_d = 1'b1;
                        rsp_dat_d = pick_word(data_q[req_idx], bus.core_req_addr[3:2]);
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                if (bus.flush) flush_pend_d = 1'b1;
                if (bus.mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (bus.flush) flush_pend_d = 1'b1;
                if (bus.mem_rsp_valid) begin
                    state_d           = RESP;
                    rsp_vld_d         = 1'b1;
                    rsp_dat_d         = pick_word(bus.mem_rsp_data, addr_q[3:2]);
                    valid_d[fill_idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_now) valid_d = '0;
        // The returned word must not move while reset holds the valid strobe low.
        if (!rst) rsp_dat_d = rsp_dat_q;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            rsp_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            rsp_vld_q    <= rsp_vld_d;
        end
    end

    // Datapath registers and line arrays; no reset needed, gated by the valid bits.
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        rsp_dat_q <= rsp_dat_d;
        if (fill_en) begin
            data_q[fill_idx] <= bus.mem_rsp_data;
            tag_q[fill_idx]  <= addr_q[31:IDX_W+4];
        end
    end
endmodule

// File: tb/tb_ama_riscv_icache.sv
// Bench for ama_riscv_icache: directed table, corner sequences, randomized run vs model.
// Memory model returns a line two cycles after the request handshake.
// Memory back-pressure is injected through stall_left.
module tb_ama_riscv_icache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ama_riscv_icache_if #(.LINE_W(128), .MEM_ADDR_W(14)) bus();

    ama_riscv_icache #(.SETS(16), .LINE_W(128), .MEM_ADDR_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int req_count = 0;
    int stall_left = 0;
    int rsp_timer = 0;
    logic [13:0] rsp_line = '0;

    typedef struct {
        logic [31:0] addr;
        int          fl_cyc;
        int          stall;
        bit          exp_miss;
        logic [31:0] exp_data;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [13:0] la, input logic [1:0] k);
        if (la == 14'h10) return 32'h1111_1111 * {30'b0, k};
        return 32'hA000_0000 | {10'b0, la, 6'b0, k};
    endfunction

    function automatic logic [127:0] mem_line(input logic [13:0] la);
        return {mem_word(la, 2'd3), mem_word(la, 2'd2), mem_word(la, 2'd1), mem_word(la, 2'd0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory port model: counts handshakes, honours stall_left, answers with fixed contents.
    initial begin
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                req_count++;
                rsp_timer = 2;
                rsp_line  = bus.mem_req_addr;
            end
            if (bus.mem_req_valid && stall_left > 0) stall_left--;
            @(posedge clk);
            #1;
            bus.mem_req_ready = (stall_left == 0);
            bus.mem_rsp_valid = 1'b0;
            if (rsp_timer > 0) begin
                rsp_timer--;
                if (rsp_timer == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_line(rsp_line);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // One read: accept in cycle 0, optional flush pulse in cycle fl_cyc, wait for the response.
    task automatic run_txn(input logic [31:0] addr, input int fl_cyc, input int stall,
                           input bit exp_miss, input logic [31:0] exp_data);
        int          rc0;
        int          lat;
        bit          got;
        logic [31:0] data;
        int          exp_lat;
        rc0 = req_count;
        got = 1'b0;
        lat = -1;
        data = '0;
        exp_lat = exp_miss ? 4 + stall : 1;
        stall_left = stall;
        @(posedge clk);
        #1;
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = addr;
        bus.flush          = (fl_cyc == 0);
        @(negedge clk);
        chk("req_ready", bus.core_req_ready, 1'b1);
        for (int c = 1; c <= 60 && !got; c++) begin
            @(posedge clk);
            #1;
            bus.core_req_valid = 1'b0;
            bus.flush          = (c == fl_cyc);
            @(negedge clk);
            if (bus.mem_req_valid) begin
                chk("mem_req_addr", bus.mem_req_addr, addr[17:4]);
                chk("ready_low_in_miss", bus.core_req_ready, 1'b0);
            end
            if (bus.core_rsp_valid) begin
                got  = 1'b1;
                lat  = c;
                data = bus.core_rsp_data;
            end
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("miss", (req_count - rc0), exp_miss ? 1 : 0);
        chk("rsp_data", data, exp_data);
        chk("latency", lat, exp_lat);
        @(negedge clk);
        chk("rsp_pulse", bus.core_rsp_valid, 1'b0);
        chk("rsp_data_held", bus.core_rsp_data, exp_data);
    endtask

    vec_t        tbl [12];
    bit          mv [16];
    logic [23:0] mt [16];

    initial begin
        tbl[0]  = '{32'h0000_0104, -1, 0, 1'b1, 32'h1111_1111};
        tbl[1]  = '{32'h0000_0500, -1, 0, 1'b1, mem_word(14'h50, 2'd0)};
        tbl[2]  = '{32'h0000_0100, -1, 0, 1'b1, 32'h0000_0000};
        tbl[3]  = '{32'h0000_0108, -1, 0, 1'b0, 32'h2222_2222};
        tbl[4]  = '{32'h0000_0234, -1, 5, 1'b1, mem_word(14'h23, 2'd1)};
        tbl[5]  = '{32'h0000_0238, -1, 0, 1'b0, mem_word(14'h23, 2'd2)};
        tbl[6]  = '{32'h0000_010C,  0, 0, 1'b1, 32'h3333_3333};
        tbl[7]  = '{32'h0000_0238, -1, 0, 1'b1, mem_word(14'h23, 2'd2)};
        tbl[8]  = '{32'h0000_03F0,  2, 0, 1'b1, mem_word(14'h3F, 2'd0)};
        tbl[9]  = '{32'h0000_03F0, -1, 0, 1'b1, mem_word(14'h3F, 2'd0)};
        tbl[10] = '{32'h0000_03FC, -1, 0, 1'b0, mem_word(14'h3F, 2'd3)};
        tbl[11] = '{32'h0000_0108, -1, 0, 1'b1, 32'h2222_2222};

        rst = 1'b0;
        bus.core_req_valid = 1'b0;
        bus.core_req_addr  = '0;
        bus.flush          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", bus.core_req_ready, 1'b1);
        chk("reset_rsp_valid", bus.core_rsp_valid, 1'b0);
        chk("reset_mem_req_valid", bus.mem_req_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            run_txn(tbl[i].addr, tbl[i].fl_cyc, tbl[i].stall, tbl[i].exp_miss, tbl[i].exp_data);

        // Hit streak on line 0x10: three requests, three consecutive responses.
        begin
            int rc0;
            rc0 = req_count;
            @(posedge clk); #1;
            bus.core_req_valid = 1'b1;
            bus.core_req_addr  = 32'h100;
            @(posedge clk); #1;
            bus.core_req_addr  = 32'h108;
            @(negedge clk);
            chk("streak0_vld", bus.core_rsp_valid, 1'b1);
            chk("streak0_dat", bus.core_rsp_data, 32'h0000_0000);
            @(posedge clk); #1;
            bus.core_req_addr  = 32'h10C;
            @(negedge clk);
            chk("streak1_vld", bus.core_rsp_valid, 1'b1);
            chk("streak1_dat", bus.core_rsp_data, 32'h2222_2222);
            @(posedge clk); #1;
            bus.core_req_valid = 1'b0;
            @(negedge clk);
            chk("streak2_vld", bus.core_rsp_valid, 1'b1);
            chk("streak2_dat", bus.core_rsp_data, 32'h3333_3333);
            chk("streak_no_mem", req_count - rc0, 0);
        end

        // Reset in MISS_WAIT; the late line response must be dropped.
        @(posedge clk); #1;
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = 32'h7E8;
        @(posedge clk); #1;
        bus.core_req_valid = 1'b0;
        @(negedge clk);
        chk("rstmiss_mem_req", bus.mem_req_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmiss_late_rsp_present", bus.mem_rsp_valid, 1'b1);
        chk("rstmiss_req_ready", bus.core_req_ready, 1'b1);
        chk("rstmiss_rsp_valid", bus.core_rsp_valid, 1'b0);
        chk("rstmiss_mem_req_valid", bus.mem_req_valid, 1'b0);
        chk("rstmiss_data_held", bus.core_rsp_data, 32'h3333_3333);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmiss_no_rsp", bus.core_rsp_valid, 1'b0);
        run_txn(32'h104, -1, 0, 1'b1, 32'h1111_1111);
        run_txn(32'h104, -1, 0, 1'b0, 32'h1111_1111);
        run_txn(32'h7E8, -1, 0, 1'b1, mem_word(14'h7E, 2'd2));

        // Randomized phase against a set-level model of the cache contents.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int s = 0; s < 16; s++) mv[s] = 1'b0;
        for (int n = 0; n < 250; n++) begin
            logic [13:0] line;
            logic [13:0] hi;
            logic [31:0] addr;
            logic [3:0]  idx;
            logic [23:0] tag;
            int          fl;
            int          st;
            int          r;
            bit          em;
            int          el;
            line = 14'($urandom_range(0, 47));
            hi   = ($urandom_range(0, 3) == 0) ? 14'h1 : 14'h0;
            addr = {hi, line, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            idx  = addr[7:4];
            tag  = addr[31:8];
            r    = $urandom_range(0, 15);
            fl   = (r < 2) ? 0 : (r < 4) ? $urandom_range(1, 5) : -1;
            st   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            em   = (fl == 0) || !(mv[idx] && mt[idx] == tag);
            el   = em ? 4 + st : 1;
            run_txn(addr, fl, st, em, mem_word(addr[17:4], addr[3:2]));
            if (fl == 0) for (int s = 0; s < 16; s++) mv[s] = 1'b0;
            if (em) begin
                mv[idx] = 1'b1;
                mt[idx] = tag;
            end
            if (fl >= 1 && fl <= el) for (int s = 0; s < 16; s++) mv[s] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ama_riscv_icache.md
Name: ama_riscv_icache

Overview:
- Direct-mapped, read-only instruction cache between the core fetch stage and the memory instruction port.
- Serves 32-bit instruction reads from 128-bit lines.
- On a miss, issues one line request to memory, fills the line, then returns the instruction.
- Supports a full invalidate (fence.i) via a flush input.

Parameters:
- SETS, 16, number of lines; power of two, minimum 2; IDX_W = log2(SETS).
- LINE_W, 128, line width in bits; equals the memory data bus width; 4 words per line.
- MEM_ADDR_W, 14, width of the memory line address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- core_req_valid  in  1  fetch request valid.
- core_req_ready  out  1  cache can accept a request this cycle.
- core_req_addr  in  32  byte address; bits [1:0] are ignored.
- core_rsp_valid  out  1  instruction valid; one-cycle pulse, no back-pressure.
- core_rsp_data  out  32  instruction word.
- flush  in  1  invalidate all lines; single-cycle pulse.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  MEM_ADDR_W  line address = core_req_addr[MEM_ADDR_W+3:4].
- mem_rsp_valid  in  1  line data valid.
- mem_rsp_data  in  LINE_W  line data.

Behaviour:
- Address split:
  - word select = addr[3:2].
  - index = addr[IDX_W+3:4].
  - tag = addr[31:IDX_W+4].
- Storage: data array SETS x LINE_W, tag array, and a valid-bit flop per line. Data and tag arrays need no reset.
- Reset (rst=0 at a clock edge) sets:
  - all valid bits to 0;
  - state to IDLE;
  - core_req_ready=1, core_rsp_valid=0, mem_req_valid=0;
  - core_rsp_data holds its value (no reset);
  - any pending flush is cleared.
- Reset mid-miss: the outstanding transaction is abandoned. A mem_rsp_valid arriving after reset is ignored in IDLE.
- State IDLE (core_req_ready=1):
  - A request is accepted when core_req_valid=1. Its address is registered.
  - Hit (line valid and tags match): core_rsp_valid=1 the next cycle, with the selected word. Back-to-back hits give 1 response per cycle.
  - Miss: go to MISS_REQ next cycle. core_req_ready=0 from that cycle on.
- State MISS_REQ:
  - mem_req_valid=1 with the registered line address; hold both until mem_req_ready=1.
  - Then go to MISS_WAIT. mem_req_valid drops the following cycle.
- State MISS_WAIT:
  - On mem_rsp_valid=1: write the data line, write the tag, set valid, and go to RESP.
- State RESP:
  - core_rsp_valid=1 with the word taken from the filled line. core_req_ready=1, returning to IDLE behaviour in the same cycle.
  - A new request accepted in RESP is looked up against the updated arrays.
- Miss penalty against the zero-wait memory (ready=1, rsp 1 cycle later): request accepted at cycle 0 -> core_rsp_valid at cycle 4.
- core_rsp_data changes only when core_rsp_valid=1.
- Flush:
  - In IDLE or RESP: all valid bits clear at that edge.
  - A request accepted in the same cycle as flush is treated as a miss.
  - During MISS_REQ or MISS_WAIT: the flush is latched as pending. The fill completes and its instruction is returned, but the valid bits are cleared in the RESP cycle, including the just-filled line.
- Index conflict: a fill replaces the resident line unconditionally.
- Memory contract:
  - At most one outstanding line request.
  - An unsolicited mem_rsp_valid outside MISS_WAIT is ignored.

Test Plan:
- Cold miss: after reset, read 0x0000_0104 with memory line 0x10 = 0x33333333_22222222_11111111_00000000 -> one mem request with addr 0x10; core_rsp_data=0x11111111 at cycle 4.
- Hit streak: then read 0x100, 0x108, 0x10C on consecutive cycles -> no mem_req_valid; responses 0x00000000, 0x22222222, 0x33333333 on consecutive cycles.
- Conflict: with SETS=16, read 0x0000_0500 (same index 0, tag 0x5) after line 0x0000_0100 is resident -> miss, refill; a re-read of 0x100 misses again.
- Back-pressure: hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stay stable; core_req_ready=0 throughout; the response arrives 5 cycles later than nominal.
- Flush mid-miss: pulse flush in MISS_WAIT -> the filled instruction is still returned; the next read of the same address misses.
- Reset mid-miss: drive rst=0 in MISS_WAIT, then release, then deliver a late mem_rsp_valid -> ignored; all outputs at reset values; the first read misses.
